clos_ingress_sched: RTL and testbench

// Priority scheduler for one Clos ingress node. Drives the node's rr_i mapping,

---
 rtl/clos_pkg.sv | 17 +
 rtl/clos_resp_tracker.sv | 43 ++++
 rtl/clos_ingress_sched.sv | 115 +++++++++++
 tb/tb_clos_ingress_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clos_pkg.sv
// Shared types and helpers for the Clos ingress priority scheduler.
package clos_pkg;

  // Per-input consecutive-loss counter.
  typedef logic [7:0] starve_cnt_t;

  // Width of an input index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Rotated priority index for middle output m. n is a power of two.
  function automatic int rot_idx(input int m, input int offset, input int n);
    return (m + offset) & (n - 1);
  endfunction

endpackage

// File: rtl/clos_resp_tracker.sv
// Response tracker: delays each expected response by Latency cycles and
// compares it with the returned valids, holding a sticky error flag.
module clos_resp_tracker
  import clos_pkg::*;
#(
  parameter int NumIn   = 2,
  parameter int Latency = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] exp_i,
  input  logic [NumIn-1:0] vld_i,
  input  logic             clr_err_i,
  output logic             err_o
);

  logic [NumIn-1:0] exp_p [Latency];
  logic             mismatch;

  assign mismatch = (exp_p[Latency-1] != vld_i);

  // Shift expected responses toward the compare point; reset discards in-flight ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) exp_p[i] <= '0;
    end else begin
      exp_p[0] <= exp_i;
      for (int i = 1; i < Latency; i++) exp_p[i] <= exp_p[i-1];
    end
  end

  // Sticky error: a mismatch always wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (mismatch) begin
      err_o <= 1'b1;
    end else if (clr_err_i) begin
      err_o <= 1'b0;
    end
  end

endmodule

// File: rtl/clos_ingress_sched.sv
// Priority scheduler for one Clos ingress node: rotates the per-middle-output
// priority mapping on losses, pins it to a starved input, and tracks responses.
module clos_ingress_sched
  import clos_pkg::*;
#(
  parameter int NumInNode   = 2,
  parameter int ClosM       = 8,
  parameter int MemLatency  = 1,
  parameter bit WriteRespOn = 1'b1,
  parameter int StarveLimit = 15,
  localparam int IdxW       = idx_w(NumInNode)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [NumInNode-1:0]  req_i,
  input  logic [NumInNode-1:0]  wen_i,
  input  logic [NumInNode-1:0]  gnt_i,
  input  logic [NumInNode-1:0]  vld_i,
  input  logic                  clr_err_i,
  output logic [ClosM*IdxW-1:0] rr_o,
  output logic [NumInNode-1:0]  starve_o,
  output logic                  err_o
);

  localparam starve_cnt_t     Limit   = starve_cnt_t'(StarveLimit);
  localparam logic [IdxW-1:0] IdxMask = IdxW'(NumInNode - 1);

  logic [IdxW-1:0]      offset_q;
  starve_cnt_t          cnt_q [NumInNode];
  logic [NumInNode-1:0] loss;
  logic [NumInNode-1:0] starve;
  logic [NumInNode-1:0] exp_rsp;
  logic                 pinned;
  logic [IdxW-1:0]      pin_idx;

  // Saturating increment of a loss counter at the starvation limit.
  function automatic starve_cnt_t sat_inc(input starve_cnt_t c);
    return (c < Limit) ? c + 8'd1 : Limit;
  endfunction

  assign loss    = req_i & ~gnt_i;
  assign pinned  = |starve;
  assign exp_rsp = gnt_i & req_i & (~wen_i | {NumInNode{WriteRespOn}});

  // Starvation flags are decoded straight from the registered counters.
  always_comb begin
    starve = '0;
    for (int k = 0; k < NumInNode; k++) starve[k] = (cnt_q[k] == Limit);
  end

  // Lowest-index starved input takes the pin.
  always_comb begin
    pin_idx = '0;
    for (int k = NumInNode - 1; k >= 0; k--) begin
      if (starve[k]) pin_idx = IdxW'(k);
    end
  end

  // Rotation offset advances on any loss, frozen while disabled or pinned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offset_q <= '0;
    end else if (en_i && (|loss) && !pinned) begin
      offset_q <= (offset_q + 1'b1) & IdxMask;
    end
  end

  // Consecutive-loss counters: cleared by a grant or an idle input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumInNode; k++) cnt_q[k] <= '0;
    end else if (en_i) begin
      for (int k = 0; k < NumInNode; k++) begin
        if (gnt_i[k] || !req_i[k]) cnt_q[k] <= '0;
        else                       cnt_q[k] <= sat_inc(cnt_q[k]);
      end
    end
  end

  // Priority mapping per middle output: pinned index or rotated index.
  always_comb begin
    rr_o = '0;
    for (int m = 0; m < ClosM; m++) begin
      rr_o[m*IdxW +: IdxW] = pinned ? pin_idx
                                    : IdxW'(rot_idx(m, int'(offset_q), NumInNode));
    end
  end

  assign starve_o = starve;

  clos_resp_tracker #(
    .NumIn   (NumInNode),
    .Latency (MemLatency)
  ) u_tracker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .exp_i     (exp_rsp),
    .vld_i     (vld_i),
    .clr_err_i (clr_err_i),
    .err_o     (err_o)
  );

  for (genvar m = 0; m < ClosM; m++) begin : g_rr_range
    a_rr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(rr_o[m*IdxW +: IdxW]) < NumInNode);
  end

  // Counters only move while enabled, so a starved input must have been requesting.
  for (genvar k = 0; k < NumInNode; k++) begin : g_starve_req
    a_starve_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (starve_o[k] && $past(en_i)) |-> $past(req_i[k]));
  end

endmodule

// File: tb/tb_clos_ingress_sched.sv
// Bench for clos_ingress_sched: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the scheduling rules.
module tb_clos_ingress_sched;
  import clos_pkg::*;

  localparam int NumInNode   = 2;
  localparam int ClosM       = 8;
  localparam int MemLatency  = 2;
  localparam bit WriteRespOn = 1'b0;
  localparam int StarveLimit = 3;
  localparam int IdxW        = idx_w(NumInNode);

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b1;
  logic                  en_i = 1'b0;
  logic [NumInNode-1:0]  req_i = '0;
  logic [NumInNode-1:0]  wen_i = '0;
  logic [NumInNode-1:0]  gnt_i = '0;
  logic [NumInNode-1:0]  vld_i = '0;
  logic                  clr_err_i = 1'b0;
  logic [ClosM*IdxW-1:0] rr_o;
  logic [NumInNode-1:0]  starve_o;
  logic                  err_o;

  clos_ingress_sched #(
    .NumInNode   (NumInNode),
    .ClosM       (ClosM),
    .MemLatency  (MemLatency),
    .WriteRespOn (WriteRespOn),
    .StarveLimit (StarveLimit)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .req_i     (req_i),
    .wen_i     (wen_i),
    .gnt_i     (gnt_i),
    .vld_i     (vld_i),
    .clr_err_i (clr_err_i),
    .rr_o      (rr_o),
    .starve_o  (starve_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  int                   m_off;
  int                   m_cnt [NumInNode];
  bit                   m_err;
  logic [NumInNode-1:0] m_expq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  task automatic model_reset();
    m_off = 0;
    m_err = 1'b0;
    for (int k = 0; k < NumInNode; k++) m_cnt[k] = 0;
    m_expq.delete();
    repeat (MemLatency) m_expq.push_back('0);
  endtask

  // Lowest starved input, or -1 when nobody is starved.
  function automatic int pin_sel();
    for (int k = 0; k < NumInNode; k++) if (m_cnt[k] == StarveLimit) return k;
    return -1;
  endfunction

  function automatic logic [ClosM*IdxW-1:0] rr_model();
    logic [ClosM*IdxW-1:0] r;
    int s, v;
    r = '0;
    s = pin_sel();
    for (int m = 0; m < ClosM; m++) begin
      v = (s >= 0) ? s : (m + m_off) % NumInNode;
      r[m*IdxW +: IdxW] = IdxW'(v);
    end
    return r;
  endfunction

  function automatic logic [NumInNode-1:0] starve_model();
    logic [NumInNode-1:0] r;
    for (int k = 0; k < NumInNode; k++) r[k] = (m_cnt[k] == StarveLimit);
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [NumInNode-1:0] expn;
    bit mism, anyloss;
    int s;
    s = pin_sel();
    anyloss = 1'b0;
    expn = '0;
    for (int k = 0; k < NumInNode; k++) begin
      expn[k] = gnt_i[k] & req_i[k] & (~wen_i[k] | WriteRespOn);
      if (req_i[k] && !gnt_i[k]) anyloss = 1'b1;
    end
    mism = (m_expq[0] != vld_i);
    if (mism) m_err = 1'b1;
    else if (clr_err_i) m_err = 1'b0;
    void'(m_expq.pop_front());
    m_expq.push_back(expn);
    if (en_i) begin
      if (anyloss && s < 0) m_off = (m_off + 1) % NumInNode;
      for (int k = 0; k < NumInNode; k++) begin
        if (gnt_i[k] || !req_i[k]) m_cnt[k] = 0;
        else if (m_cnt[k] < StarveLimit) m_cnt[k]++;
      end
    end
  endtask

  // Apply inputs for one cycle, clock, then compare outputs at the falling edge.
  task automatic step(input logic en, input logic [NumInNode-1:0] req, input logic [NumInNode-1:0] wen,
                      input logic [NumInNode-1:0] gnt, input logic [NumInNode-1:0] vld, input logic clr);
    en_i = en; req_i = req; wen_i = wen; gnt_i = gnt; vld_i = vld; clr_err_i = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("rr_o", 32'(rr_o), 32'(rr_model()));
    chk("starve_o", 32'(starve_o), 32'(starve_model()));
    chk("err_o", 32'(err_o), 32'(m_err));
  endtask

  // Asynchronous reset in the middle of a low clock phase, with noisy inputs.
  task automatic do_reset();
    #3;
    rst_ni = 1'b0;
    en_i = 1'($urandom); req_i = NumInNode'($urandom); wen_i = NumInNode'($urandom);
    gnt_i = NumInNode'($urandom); vld_i = NumInNode'($urandom); clr_err_i = 1'($urandom);
    #1;
    chk("rst_rr", 32'(rr_o), 32'h0000_00AA);
    chk("rst_starve", 32'(starve_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    vld_i = '0;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NumInNode-1:0] rq, gt, wn, vl;
    model_reset();
    do_reset();

    // Rotation on repeated losses of input 1, then starvation and release.
    step(1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
    chk("rot_rr0_a", 32'(rr_o[IdxW-1:0]), 32'd1);
    step(1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
    chk("rot_rr0_b", 32'(rr_o[IdxW-1:0]), 32'd0);
    step(1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
    chk("rot_rr0_c", 32'(rr_o[IdxW-1:0]), 32'd1);
    chk("pin_starve", 32'(starve_o), 32'h2);
    chk("pin_rr", 32'(rr_o), 32'hFF);
    step(1'b1, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0);
    chk("unpin_starve", 32'(starve_o), 32'h0);
    chk("unpin_rr", 32'(rr_o), 32'h55);
    step(1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);

    // Tracking: read answered on time, then a write that returns nothing.
    do_reset();
    step(1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    chk("trk_read_ok", 32'(err_o), 32'h0);
    repeat (3) step(1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0);
    chk("trk_write_ok", 32'(err_o), 32'h0);

    // Tracking: early response, sticky error, clear, clear losing to a mismatch.
    step(1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0);
    chk("trk_early", 32'(err_o), 32'h1);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("trk_sticky", 32'(err_o), 32'h1);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    chk("trk_clear", 32'(err_o), 32'h0);
    step(1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    chk("trk_clr_vs_mism", 32'(err_o), 32'h1);

    // Freeze: counters preloaded, then held through 20 losing cycles.
    do_reset();
    repeat (2) step(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    repeat (20) step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("frz_rr", 32'(rr_o), 32'hAA);
    chk("frz_starve", 32'(starve_o), 32'h0);
    step(1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("frz_trk_miss", 32'(err_o), 32'h1);
    step(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("frz_resume_starve", 32'(starve_o), 32'h3);
    chk("frz_resume_rr", 32'(rr_o), 32'h00);

    // Randomized traffic with occasional response faults, clears and a mid-run reset.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      for (int k = 0; k < NumInNode; k++) begin
        rq[k] = ($urandom_range(3) != 0);
        gt[k] = rq[k] & ($urandom_range(2) == 0);
      end
      wn = NumInNode'($urandom);
      vl = m_expq[0];
      if ($urandom_range(15) == 0) vl = vl ^ NumInNode'($urandom_range(1, (1 << NumInNode) - 1));
      step(($urandom_range(7) != 0), rq, wn, gt, vl, ($urandom_range(7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
